// File: rtl/rgb_window_filter.sv
// ============================================================================
// Module      : rgb_window_filter
// Description : 3x3-window RGB filter (pass, mask, gray, blur, sharpen),
//               3-stage pipeline with valid/SOF sideband.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rgb_window_filter #(
    parameter int CW = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [2:0]        mode,
    input  logic [2:0]        chan_mask,
    input  logic              in_valid,
    input  logic              in_sof,
    input  logic [27*CW-1:0]  color_data,
    output logic              out_valid,
    output logic              out_sof,
    output logic [3*CW-1:0]   filter_rgb_out,
    output logic [3*CW-1:0]   original_out
);

    localparam int PW = 3 * CW;
    localparam int RW = CW + 4;

    localparam logic [2:0] c_MODE_PASS  = 3'd0;
    localparam logic [2:0] c_MODE_MASK  = 3'd1;
    localparam logic [2:0] c_MODE_GRAY  = 3'd2;
    localparam logic [2:0] c_MODE_BLUR  = 3'd3;
    localparam logic [2:0] c_MODE_SHARP = 3'd4;

    // Pixel slots in the packed window; centre sits in the MSBs.
    localparam int c_P_C  = 8;
    localparam int c_P_L  = 7;
    localparam int c_P_R  = 6;
    localparam int c_P_U  = 5;
    localparam int c_P_D  = 4;
    localparam int c_P_UL = 3;
    localparam int c_P_UR = 2;
    localparam int c_P_DL = 1;
    localparam int c_P_DR = 0;

    // ------------------------------------------------------------------
    // Active configuration, reloaded only on a valid start-of-frame beat
    // ------------------------------------------------------------------
    logic [2:0] act_mode_q, act_mode_d;
    logic [2:0] act_mask_q, act_mask_d;
    logic       w_cfg_load;

    always_comb begin
        w_cfg_load = in_valid & in_sof;
        act_mode_d = act_mode_q;
        act_mask_d = act_mask_q;
        if (w_cfg_load) begin
            act_mode_d = mode;
            act_mask_d = chan_mask;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            act_mode_q <= c_MODE_PASS;
            act_mask_q <= 3'b111;
        end else begin
            act_mode_q <= act_mode_d;
            act_mask_q <= act_mask_d;
        end
    end

    // ------------------------------------------------------------------
    // Stage 1: capture window and the configuration that applies to it
    // ------------------------------------------------------------------
    logic                         s1_valid_q;
    logic                         s1_sof_q;
    logic [2:0]                   s1_mode_q;
    logic [2:0]                   s1_mask_q;
    logic [8:0][2:0][CW-1:0]      s1_pix_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            s1_valid_q <= 1'b0;
            s1_sof_q   <= 1'b0;
            s1_mode_q  <= c_MODE_PASS;
            s1_mask_q  <= 3'b111;
            s1_pix_q   <= '0;
        end else begin
            s1_valid_q <= in_valid;
            s1_sof_q   <= in_valid & in_sof;
            if (in_valid) begin
                s1_pix_q  <= color_data;
                s1_mode_q <= act_mode_d;
                s1_mask_q <= act_mask_d;
            end
        end
    end

    // Luma is shared by all three channels.
    logic [CW+1:0] w_gray_sum;
    logic [CW+1:0] w_gray;

    always_comb begin
        w_gray_sum = {2'b00, s1_pix_q[c_P_C][2]}
                   + {1'b0, s1_pix_q[c_P_C][1], 1'b0}
                   + {2'b00, s1_pix_q[c_P_C][0]};
        w_gray     = w_gray_sum >> 2;
    end

    // ------------------------------------------------------------------
    // Stage 2 arithmetic and stage 3 saturation, per channel (2=R,1=G,0=B)
    // ------------------------------------------------------------------
    logic [2:0][RW-1:0] w_res;
    logic [2:0][RW-1:0] s2_res_q;
    logic [2:0][CW-1:0] w_sat;

    for (genvar ch = 0; ch < 3; ch++) begin : g_chan
        logic [RW-1:0] w_cx;
        logic [RW-1:0] w_sum4;
        logic [RW-1:0] w_diag;
        logic [RW-1:0] w_blur_sum;
        logic [RW-1:0] w_blur;
        logic [RW-1:0] w_sharp;
        logic [RW-1:0] w_sel;

        always_comb begin
            w_cx       = RW'(s1_pix_q[c_P_C][ch]);
            w_sum4     = RW'(s1_pix_q[c_P_L][ch]) + RW'(s1_pix_q[c_P_R][ch])
                       + RW'(s1_pix_q[c_P_U][ch]) + RW'(s1_pix_q[c_P_D][ch]);
            w_diag     = RW'(s1_pix_q[c_P_UL][ch]) + RW'(s1_pix_q[c_P_UR][ch])
                       + RW'(s1_pix_q[c_P_DL][ch]) + RW'(s1_pix_q[c_P_DR][ch]);
            w_blur_sum = (w_cx << 2) + (w_sum4 << 1) + w_diag;
            w_blur     = w_blur_sum >> 4;
            // Two's-complement result; 5*M always fits in RW signed bits.
            w_sharp    = (w_cx << 2) + w_cx - w_sum4;

            w_sel = w_cx;
            case (s1_mode_q)
                c_MODE_MASK:  w_sel = s1_mask_q[ch] ? w_cx : '0;
                c_MODE_GRAY:  w_sel = {2'b00, w_gray};
                c_MODE_BLUR:  w_sel = w_blur;
                c_MODE_SHARP: w_sel = w_sharp;
                default:      w_sel = w_cx;
            endcase
        end

        assign w_res[ch] = w_sel;

        assign w_sat[ch] = s2_res_q[ch][RW-1]        ? '0 :
                           (|s2_res_q[ch][RW-2:CW])  ? {CW{1'b1}} :
                                                       s2_res_q[ch][CW-1:0];
    end

    // ------------------------------------------------------------------
    // Stage 2 registers
    // ------------------------------------------------------------------
    logic          s2_valid_q;
    logic          s2_sof_q;
    logic [PW-1:0] s2_centre_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            s2_valid_q  <= 1'b0;
            s2_sof_q    <= 1'b0;
            s2_res_q    <= '0;
            s2_centre_q <= '0;
        end else begin
            s2_valid_q <= s1_valid_q;
            s2_sof_q   <= s1_sof_q;
            if (s1_valid_q) begin
                s2_res_q    <= w_res;
                s2_centre_q <= s1_pix_q[c_P_C];
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage 3 registers drive the outputs directly
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset) begin
            out_valid      <= 1'b0;
            out_sof        <= 1'b0;
            filter_rgb_out <= '0;
            original_out   <= '0;
        end else begin
            out_valid <= s2_valid_q;
            out_sof   <= s2_sof_q;
            if (s2_valid_q) begin
                filter_rgb_out <= w_sat;
                original_out   <= s2_centre_q;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_rgb_window_filter.sv
// ============================================================================
// Module      : tb_rgb_window_filter
// Description : Directed self-checking bench for rgb_window_filter (CW=4).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rgb_window_filter;

    localparam int CW = 4;
    localparam int PW = 3 * CW;

    logic              clk = 1'b0;
    logic              reset;
    logic [2:0]        mode;
    logic [2:0]        chan_mask;
    logic              in_valid;
    logic              in_sof;
    logic [9*PW-1:0]   color_data;
    logic              out_valid;
    logic              out_sof;
    logic [PW-1:0]     filter_rgb_out;
    logic [PW-1:0]     original_out;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    rgb_window_filter #(.CW(CW)) u_dut (
        .clk            (clk),
        .reset          (reset),
        .mode           (mode),
        .chan_mask      (chan_mask),
        .in_valid       (in_valid),
        .in_sof         (in_sof),
        .color_data     (color_data),
        .out_valid      (out_valid),
        .out_sof        (out_sof),
        .filter_rgb_out (filter_rgb_out),
        .original_out   (original_out)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [9*PW-1:0] win(
        input logic [PW-1:0] c,  input logic [PW-1:0] l,  input logic [PW-1:0] r,
        input logic [PW-1:0] u,  input logic [PW-1:0] d,  input logic [PW-1:0] ul,
        input logic [PW-1:0] ur, input logic [PW-1:0] dl, input logic [PW-1:0] dr);
        return {c, l, r, u, d, ul, ur, dl, dr};
    endfunction

    // One isolated window; result must appear exactly on the third negedge.
    task automatic one(input string tag, input logic s, input logic [2:0] m,
                       input logic [2:0] k, input logic [9*PW-1:0] w,
                       input logic [PW-1:0] exp);
        @(negedge clk);
        in_valid = 1'b1; in_sof = s; mode = m; chan_mask = k; color_data = w;
        @(negedge clk);
        in_valid = 1'b0; in_sof = 1'b0;
        chk({tag, "/v1"}, out_valid, 0);
        chk({tag, "/s1"}, out_sof, 0);
        @(negedge clk);
        chk({tag, "/v2"}, out_valid, 0);
        chk({tag, "/s2"}, out_sof, 0);
        @(negedge clk);
        chk({tag, "/valid"}, out_valid, 1);
        chk({tag, "/filt"},  filter_rgb_out, exp);
        chk({tag, "/orig"},  original_out, w[9*PW-1 -: PW]);
        chk({tag, "/sof"},   out_sof, s);
    endtask

    initial begin
        logic [3:0] pv;
        reset = 1'b0; in_valid = 1'b0; in_sof = 1'b0;
        mode = 3'd0; chan_mask = 3'd0; color_data = '0;

        repeat (2) @(negedge clk);
        chk("rst/valid", out_valid, 0);
        chk("rst/sof",   out_sof, 0);
        chk("rst/filt",  filter_rgb_out, 0);
        chk("rst/orig",  original_out, 0);
        reset = 1'b1;

        one("lat", 1'b1, 3'd0, 3'b111, win(12'hA5C, 12'h111, 12'h222, 12'h333, 12'h444,
            12'h555, 12'h666, 12'h777, 12'h888), 12'hA5C);

        one("mask_b",    1'b1, 3'd1, 3'b001, {9{12'hFFF}}, 12'h00F);
        one("mask_hold", 1'b0, 3'd0, 3'b111, win(12'h123, 0, 0, 0, 0, 0, 0, 0, 0), 12'h003);

        one("gray", 1'b1, 3'd2, 3'b000, win(12'h48C, 0, 0, 0, 0, 0, 0, 0, 0), 12'h888);

        one("blur_ones", 1'b1, 3'd3, 3'b000, {9{12'hFFF}}, 12'hFFF);
        one("blur_ctr",  1'b1, 3'd3, 3'b000, win(12'hF00, 0, 0, 0, 0, 0, 0, 0, 0), 12'h300);
        one("blur_edge", 1'b0, 3'd0, 3'b000, win(12'h000, 12'hFFF, 0, 0, 0, 12'hFFF, 0, 0, 0), 12'h222);

        one("sh_hi",  1'b1, 3'd4, 3'b000, win(12'hFFF, 0, 0, 0, 0, 0, 0, 0, 0), 12'hFFF);
        one("sh_lo",  1'b1, 3'd4, 3'b000, win(12'h000, 12'hFFF, 12'hFFF, 12'hFFF, 12'hFFF,
            0, 0, 0, 0), 12'h000);
        one("sh_mid", 1'b1, 3'd4, 3'b000, win(12'h888, 12'h777, 12'h777, 12'h777, 12'h777,
            12'hFFF, 12'hFFF, 12'hFFF, 12'hFFF), 12'hCCC);

        one("mode5", 1'b1, 3'd5, 3'b000, win(12'h5A3, 12'hFFF, 0, 0, 0, 0, 0, 0, 0), 12'h5A3);

        // SOF without valid must neither reload the mode nor emerge as out_sof.
        @(negedge clk);
        in_valid = 1'b0; in_sof = 1'b1; mode = 3'd2;
        one("sof_novalid", 1'b0, 3'd2, 3'b000, win(12'h48C, 0, 0, 0, 0, 0, 0, 0, 0), 12'h48C);

        // Gap pattern 1,0,1,1 must reappear unchanged three cycles later.
        pv = 4'b1101;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (i >= 3) begin
                chk("bub/valid", out_valid, (i - 3 < 4) ? pv[i-3] : 1'b0);
                chk("bub/sof",   out_sof, (i == 3) ? 1'b1 : 1'b0);
                if (i - 3 < 4 && pv[i-3])
                    chk("bub/filt", filter_rgb_out, 12'h100 + 12'(i - 3));
            end
            if (i < 4) begin
                in_valid   = pv[i];
                in_sof     = (i == 0);
                mode       = 3'd0;
                color_data = pv[i] ? win(12'h100 + 12'(i), 0, 0, 0, 0, 0, 0, 0, 0)
                                   : {9{12'hBAD}};
            end else begin
                in_valid = 1'b0;
                in_sof   = 1'b0;
            end
        end

        // Reset with two windows in flight: both must be dropped.
        @(negedge clk);
        in_valid = 1'b1; in_sof = 1'b1; mode = 3'd4;
        color_data = win(12'hFFF, 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        in_sof = 1'b0; color_data = win(12'h0FF, 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        in_valid = 1'b0; reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        chk("mrst/valid", out_valid, 0);
        chk("mrst/sof",   out_sof, 0);
        chk("mrst/filt",  filter_rgb_out, 0);
        chk("mrst/orig",  original_out, 0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("mrst/flush", out_valid, 0);
        end

        // Reset must have restored pass mode.
        one("rst_mode", 1'b0, 3'd2, 3'b000, win(12'h48C, 0, 0, 0, 0, 0, 0, 0, 0), 12'h48C);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
